// File: rtl/mult_pkg.sv
// Shared definitions for the systolic matrix-vector multiplier and its
// downstream result drain: default geometry, result word width and the
// drain state encoding.
package mult_pkg;

  // Default number of lanes / result words.
  localparam int DEF_N     = 8;
  // Default operand width.
  localparam int DEF_WIDTH = 8;
  // Accumulator / result word width, shared with the multiplier.
  localparam int RES_W     = 3 * DEF_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    SETTLE = 3'd2,
    DRAIN  = 3'd3,
    CLEAR  = 3'd4
  } drain_state_e;

endpackage

// File: rtl/result_drain.sv
// result_drain: downstream stage of the systolic matrix-vector multiplier.
// After a job is armed it waits for a fresh rising edge of the multiplier's
// done level, lets the last MAC lanes settle for SETTLE_CYC cycles, snapshots
// all N accumulators and streams them one word per valid/ready handshake.
// Once the last word is accepted it pulses clr to the multiplier for one cycle.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   arm         one-cycle pulse when a job's En is issued
//   done        multiplier done level (all FIFOs empty)
//   C           N accumulator outputs, lane i on C[i]
//   res_ready   consumer ready
//   res_valid   result word valid
//   res_data    result word (snapshot of lane res_idx)
//   res_idx     lane index of res_data
//   clr         one-cycle clear pulse to the multiplier
//   busy        high whenever the drain is not idle
//   drain_done  one-cycle pulse after the last word is accepted
//   ovr         sticky protocol-error flag (arm while busy, or a done rise
//               after the settle period has started)
module result_drain
  import mult_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SETTLE_CYC = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          arm,
  input  logic                          done,
  input  logic [N-1:0][3*WIDTH-1:0]     C,
  input  logic                          res_ready,
  output logic                          res_valid,
  output logic [3*WIDTH-1:0]            res_data,
  output logic [$clog2(N)-1:0]          res_idx,
  output logic                          clr,
  output logic                          busy,
  output logic                          drain_done,
  output logic                          ovr
);

  localparam int RW = 3 * WIDTH;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX    = IW'(N - 1);
  localparam logic [7:0]    SETTLE_LOAD = (SETTLE_CYC > 0) ? 8'(SETTLE_CYC - 1) : 8'd0;

  drain_state_e           state_r;
  drain_state_e           state_nxt_s;
  logic                   done_q_r;
  logic                   rise_s;
  logic [7:0]             cnt_r;
  logic [7:0]             cnt_nxt_s;
  logic [IW-1:0]          idx_r;
  logic [IW-1:0]          idx_nxt_s;
  logic                   capture_s;
  logic                   ovr_set_s;
  logic [N-1:0][RW-1:0]   snap_r;

  logic                   res_valid_r;
  logic [RW-1:0]          res_data_r;
  logic [IW-1:0]          res_idx_r;
  logic                   clr_r;
  logic                   busy_r;
  logic                   drain_done_r;
  logic                   ovr_r;

  // Only a fresh 0->1 transition of done counts; a level left high by the
  // previous job is ignored.
  assign rise_s = done & ~done_q_r;

  // Next-state, counter, index and protocol-error decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    capture_s   = 1'b0;
    ovr_set_s   = 1'b0;

    case (state_r)
      IDLE: begin
        // A rise coinciding with arm is not consumed here.
        if (arm) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMED: begin
        if (rise_s) begin
          if (SETTLE_CYC == 0) begin
            capture_s   = 1'b1;
            idx_nxt_s   = {IW{1'b0}};
            state_nxt_s = DRAIN;
          end else begin
            cnt_nxt_s   = SETTLE_LOAD;
            state_nxt_s = SETTLE;
          end
        end else begin
          state_nxt_s = ARMED;
        end
      end
      SETTLE: begin
        if (cnt_r == 8'd0) begin
          capture_s   = 1'b1;
          idx_nxt_s   = {IW{1'b0}};
          state_nxt_s = DRAIN;
        end else begin
          cnt_nxt_s   = cnt_r - 8'd1;
        end
      end
      DRAIN: begin
        // res_valid is always high in DRAIN, so ready alone marks a handshake.
        if (res_ready) begin
          if (idx_r == LAST_IDX) begin
            idx_nxt_s   = {IW{1'b0}};
            state_nxt_s = CLEAR;
          end else begin
            idx_nxt_s   = idx_r + IW'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      CLEAR: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    if ((arm && (state_r != IDLE)) ||
        (rise_s && ((state_r == SETTLE) || (state_r == DRAIN) || (state_r == CLEAR)))) begin
      ovr_set_s = 1'b1;
    end else begin
      ovr_set_s = 1'b0;
    end
  end

  // State, snapshot bank and registered outputs. Outputs are computed from the
  // next state so they line up with the state they describe; in the capture
  // cycle word 0 is taken straight from C since snap_r is loaded on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      done_q_r     <= 1'b0;
      cnt_r        <= 8'd0;
      idx_r        <= {IW{1'b0}};
      snap_r       <= {(N*RW){1'b0}};
      res_valid_r  <= 1'b0;
      res_data_r   <= {RW{1'b0}};
      res_idx_r    <= {IW{1'b0}};
      clr_r        <= 1'b0;
      busy_r       <= 1'b0;
      drain_done_r <= 1'b0;
      ovr_r        <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      done_q_r <= done;
      cnt_r    <= cnt_nxt_s;
      idx_r    <= idx_nxt_s;
      if (capture_s) begin
        snap_r <= C;
      end else begin
        snap_r <= snap_r;
      end
      ovr_r        <= ovr_r | ovr_set_s;
      res_valid_r  <= (state_nxt_s == DRAIN);
      if (state_nxt_s == DRAIN) begin
        res_idx_r  <= idx_nxt_s;
        res_data_r <= capture_s ? C[idx_nxt_s] : snap_r[idx_nxt_s];
      end else begin
        res_idx_r  <= {IW{1'b0}};
        res_data_r <= {RW{1'b0}};
      end
      clr_r        <= (state_nxt_s == CLEAR);
      drain_done_r <= (state_nxt_s == CLEAR);
      busy_r       <= (state_nxt_s != IDLE);
    end
  end

  assign res_valid  = res_valid_r;
  assign res_data   = res_data_r;
  assign res_idx    = res_idx_r;
  assign clr        = clr_r;
  assign busy       = busy_r;
  assign drain_done = drain_done_r;
  assign ovr        = ovr_r;

endmodule
